// File: rtl/dual_port_block_ram.sv
// -----------------------------------------------------------------------------
// dual_port_block_ram
//
// Simple dual-port RAM: one write port, one read port, single clock.
// Each entry carries a valid bit that is set by any non-empty byte-masked write
// and cleared by reset. Reads return zero data / valid=0 for entries that have
// not been written since reset, and for out-of-range addresses.
//
// Ports
//   clk_in                         : clock, all logic rising-edge
//   reset_in                       : synchronous active-low reset
//   write_port_access_en_in        : write request
//   write_port_write_en_in         : byte write enables (bit i -> data[8i+7:8i])
//   write_port_access_set_addr_in  : write entry index
//   write_port_data_in             : write data
//   read_port_access_en_in         : read request
//   read_port_access_set_addr_in   : read entry index
//   read_port_data_out             : registered read data
//   read_port_valid_out            : registered "entry written since reset" flag
//
// Configuration
//   CONFIG_MODE                    : "WriteFirst" or "ReadFirst" collision policy
//   DUAL_PORT_BLOCK_RAM_OUTPUT_REG_EN (macro): adds an output register stage,
//                                    read latency becomes 2 cycles.
// -----------------------------------------------------------------------------
module dual_port_block_ram #(
    parameter int    SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int    NUM_SET                    = 64,
    parameter int    SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter string CONFIG_MODE                = "WriteFirst",
    localparam int   WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / 8
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  write_port_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]             write_port_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_port_access_set_addr_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_in,
    input  logic                                  read_port_access_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_out,
    output logic                                  read_port_valid_out
);

    localparam bit WRITE_FIRST = (CONFIG_MODE == "WriteFirst");

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_q [NUM_SET];
    logic [NUM_SET-1:0]                    valid_q;
    logic [NUM_SET-1:0]                    valid_d;

    logic                                  wr_in_range;
    logic                                  rd_in_range;
    logic                                  wr_fire;
    logic                                  collision;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] wr_old;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] wr_merged;

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] rd_data_q;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] rd_data_d;
    logic                                  rd_valid_q;
    logic                                  rd_valid_d;

    // Write-side decode and byte merge. Bytes of an entry that has never been
    // written are treated as zero, so a partial first write leaves the
    // untouched bytes deterministic rather than whatever the array held.
    always_comb begin
        wr_in_range = 32'(write_port_access_set_addr_in) < 32'(NUM_SET);
        rd_in_range = 32'(read_port_access_set_addr_in) < 32'(NUM_SET);
        wr_fire     = reset_in && write_port_access_en_in &&
                      (|write_port_write_en_in) && wr_in_range;
        collision   = wr_fire &&
                      (write_port_access_set_addr_in == read_port_access_set_addr_in);

        wr_old = '0;
        if (wr_in_range && valid_q[write_port_access_set_addr_in]) begin
            wr_old = mem_q[write_port_access_set_addr_in];
        end

        wr_merged = wr_old;
        for (int unsigned i = 0; i < WRITE_MASK_LEN; i++) begin
            if (write_port_write_en_in[i]) begin
                wr_merged[8*i +: 8] = write_port_data_in[8*i +: 8];
            end
        end

        valid_d = valid_q;
        if (!reset_in) begin
            valid_d = '0;
        end else if (wr_fire) begin
            valid_d[write_port_access_set_addr_in] = 1'b1;
        end
    end

    // Read-side next state: hold when idle, bypass merged data on a
    // write-first collision, otherwise return stored contents gated by valid.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (!reset_in) begin
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
        end else if (read_port_access_en_in) begin
            if (!rd_in_range) begin
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
            end else if (collision && WRITE_FIRST) begin
                rd_data_d  = wr_merged;
                rd_valid_d = 1'b1;
            end else if (valid_q[read_port_access_set_addr_in]) begin
                rd_data_d  = mem_q[read_port_access_set_addr_in];
                rd_valid_d = 1'b1;
            end else begin
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
            end
        end
    end

    // Data array has no reset so it can map onto RAM resources.
    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem_q[write_port_access_set_addr_in] <= wr_merged;
        end
    end

    always_ff @(posedge clk_in) begin
        valid_q    <= valid_d;
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
    end

`ifdef DUAL_PORT_BLOCK_RAM_OUTPUT_REG_EN
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] out_data_q;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] out_data_d;
    logic                                  out_valid_q;
    logic                                  out_valid_d;

    always_comb begin
        out_data_d  = rd_data_q;
        out_valid_d = rd_valid_q;
        if (!reset_in) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
    end

    assign read_port_data_out  = out_data_q;
    assign read_port_valid_out = out_valid_q;
`else
    assign read_port_data_out  = rd_data_q;
    assign read_port_valid_out = rd_valid_q;
`endif

endmodule

// File: tb/tb_dual_port_block_ram.sv
module tb_dual_port_block_ram;

    logic        clk_in;
    logic        reset_in;
    logic        write_port_access_en_in;
    logic [7:0]  write_port_write_en_in;
    logic [5:0]  write_port_access_set_addr_in;
    logic [63:0] write_port_data_in;
    logic        read_port_access_en_in;
    logic [5:0]  read_port_access_set_addr_in;
    logic [63:0] wf_data;
    logic        wf_valid;
    logic [63:0] rf_data;
    logic        rf_valid;

    int total;
    int bad;

    dual_port_block_ram #(
        .SINGLE_ENTRY_WIDTH_IN_BITS (64),
        .NUM_SET                    (64),
        .CONFIG_MODE                ("WriteFirst")
    ) u_wf (
        .clk_in                        (clk_in),
        .reset_in                      (reset_in),
        .write_port_access_en_in       (write_port_access_en_in),
        .write_port_write_en_in        (write_port_write_en_in),
        .write_port_access_set_addr_in (write_port_access_set_addr_in),
        .write_port_data_in            (write_port_data_in),
        .read_port_access_en_in        (read_port_access_en_in),
        .read_port_access_set_addr_in  (read_port_access_set_addr_in),
        .read_port_data_out            (wf_data),
        .read_port_valid_out           (wf_valid)
    );

    dual_port_block_ram #(
        .SINGLE_ENTRY_WIDTH_IN_BITS (64),
        .NUM_SET                    (64),
        .CONFIG_MODE                ("ReadFirst")
    ) u_rf (
        .clk_in                        (clk_in),
        .reset_in                      (reset_in),
        .write_port_access_en_in       (write_port_access_en_in),
        .write_port_write_en_in        (write_port_write_en_in),
        .write_port_access_set_addr_in (write_port_access_set_addr_in),
        .write_port_data_in            (write_port_data_in),
        .read_port_access_en_in        (read_port_access_en_in),
        .read_port_access_set_addr_in  (read_port_access_set_addr_in),
        .read_port_data_out            (rf_data),
        .read_port_valid_out           (rf_valid)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One access cycle; enables are dropped afterwards and, with the output
    // register stage, one more edge lets the result reach the outputs.
    task automatic cycle(input logic we, input logic [7:0] mask, input logic [5:0] wa,
                         input logic [63:0] wd, input logic re, input logic [5:0] ra);
        write_port_access_en_in       = we;
        write_port_write_en_in        = mask;
        write_port_access_set_addr_in = wa;
        write_port_data_in            = wd;
        read_port_access_en_in        = re;
        read_port_access_set_addr_in  = ra;
        tick();
        write_port_access_en_in = 1'b0;
        write_port_write_en_in  = '0;
        read_port_access_en_in  = 1'b0;
`ifdef DUAL_PORT_BLOCK_RAM_OUTPUT_REG_EN
        tick();
`endif
    endtask

    task automatic wr(input logic [7:0] mask, input logic [5:0] wa, input logic [63:0] wd);
        cycle(1'b1, mask, wa, wd, 1'b0, '0);
    endtask

    task automatic rd(input logic [5:0] ra);
        cycle(1'b0, '0, '0, '0, 1'b1, ra);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_in                      = 1'b0;
        write_port_access_en_in       = 1'b0;
        write_port_write_en_in        = '0;
        write_port_access_set_addr_in = '0;
        write_port_data_in            = '0;
        read_port_access_en_in        = 1'b0;
        read_port_access_set_addr_in  = '0;
        tick();
        tick();
        tick();
        check("rst_wf_data",  wf_data, 64'h0);
        check("rst_wf_valid", {63'h0, wf_valid}, 64'h0);
        check("rst_rf_valid", {63'h0, rf_valid}, 64'h0);
        reset_in = 1'b1;
        tick();

        // never-written entry
        rd(6'd1);
        check("unwritten_data",  wf_data, 64'h0);
        check("unwritten_valid", {63'h0, wf_valid}, 64'h0);

        // full write then read back
        wr(8'hFF, 6'd63, 64'h5555_5555_5555_5555);
        rd(6'd63);
        check("s63_data",  wf_data, 64'h5555_5555_5555_5555);
        check("s63_valid", {63'h0, wf_valid}, 64'h1);

        // independent write/read in the same cycle
        cycle(1'b1, 8'hFF, 6'd1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 6'd63);
        check("indep_data",  wf_data, 64'h5555_5555_5555_5555);
        check("indep_valid", {63'h0, wf_valid}, 64'h1);
        rd(6'd1);
        check("s1_data",  wf_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check("s1_valid", {63'h0, wf_valid}, 64'h1);

        // idle cycles with a different address hold the outputs
        read_port_access_set_addr_in = 6'd63;
        tick();
        tick();
        check("hold_data",  wf_data, 64'hAAAA_AAAA_AAAA_AAAA);
        check("hold_valid", {63'h0, wf_valid}, 64'h1);

        // partial write on an unwritten entry
        wr(8'h0F, 6'd5, 64'h1122_3344_5566_7788);
        rd(6'd5);
        check("s5_part_data",  wf_data, 64'h0000_0000_5566_7788);
        check("s5_part_valid", {63'h0, wf_valid}, 64'h1);

        // all-zero mask changes nothing
        wr(8'h00, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(6'd6);
        check("zmask_data",  wf_data, 64'h0);
        check("zmask_valid", {63'h0, wf_valid}, 64'h0);

        // collision on an unwritten entry
        cycle(1'b1, 8'hFF, 6'd7, 64'hDEAD_BEEF_0000_0000, 1'b1, 6'd7);
        check("coll_wf_data",  wf_data, 64'hDEAD_BEEF_0000_0000);
        check("coll_wf_valid", {63'h0, wf_valid}, 64'h1);
        check("coll_rf_data",  rf_data, 64'h0);
        check("coll_rf_valid", {63'h0, rf_valid}, 64'h0);
        rd(6'd7);
        check("after_coll_rf_data",  rf_data, 64'hDEAD_BEEF_0000_0000);
        check("after_coll_rf_valid", {63'h0, rf_valid}, 64'h1);

        // partial-mask collision on a written entry
        cycle(1'b1, 8'hF0, 6'd5, 64'hAABB_CCDD_0000_0000, 1'b1, 6'd5);
        check("pcoll_wf_data", wf_data, 64'hAABB_CCDD_5566_7788);
        check("pcoll_rf_data", rf_data, 64'h0000_0000_5566_7788);
        check("pcoll_rf_valid", {63'h0, rf_valid}, 64'h1);

        // reset mid-operation with a same-edge write
        reset_in                      = 1'b0;
        write_port_access_en_in       = 1'b1;
        write_port_write_en_in        = 8'hFF;
        write_port_access_set_addr_in = 6'd10;
        write_port_data_in            = 64'h0123_4567_89AB_CDEF;
        read_port_access_en_in        = 1'b1;
        read_port_access_set_addr_in  = 6'd63;
        tick();
        write_port_access_en_in = 1'b0;
        write_port_write_en_in  = '0;
        read_port_access_en_in  = 1'b0;
        tick();
        check("midrst_data",  wf_data, 64'h0);
        check("midrst_valid", {63'h0, wf_valid}, 64'h0);
        reset_in = 1'b1;
        tick();
        rd(6'd63);
        check("post_rst_s63_data",  wf_data, 64'h0);
        check("post_rst_s63_valid", {63'h0, wf_valid}, 64'h0);
        rd(6'd10);
        check("post_rst_s10_valid", {63'h0, wf_valid}, 64'h0);

        // partial write after reset merges with zero, not stale contents
        wr(8'h01, 6'd63, 64'hFFFF_FFFF_FFFF_FFAB);
        rd(6'd63);
        check("post_rst_part_data",  wf_data, 64'h0000_0000_0000_00AB);
        check("post_rst_part_valid", {63'h0, wf_valid}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_block_ram.md
DUAL_PORT_BLOCK_RAM -- requirements
Module: dual_port_block_ram

Interface
REQ-001 Parameters SHALL be:
- SINGLE_ENTRY_WIDTH_IN_BITS, default 64, entry width (multiple of 8).
- NUM_SET, default 64, number of entries.
- SET_PTR_WIDTH_IN_BITS, default $clog2(NUM_SET), address width.
- CONFIG_MODE, default "WriteFirst", same-address collision policy ("WriteFirst" or "ReadFirst").
REQ-002 WRITE_MASK_LEN SHALL be a derived localparam equal to SINGLE_ENTRY_WIDTH_IN_BITS/8.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_in, in, 1, sole clock; all logic rising-edge.
- reset_in, in, 1, synchronous active-low reset.
- write_port_access_en_in, in, 1, write request.
- write_port_write_en_in, in, WRITE_MASK_LEN, byte write enables; bit i covers data bits [8i+7:8i].
- write_port_access_set_addr_in, in, SET_PTR_WIDTH_IN_BITS, write entry index.
- write_port_data_in, in, SINGLE_ENTRY_WIDTH_IN_BITS, write data.
- read_port_access_en_in, in, 1, read request.
- read_port_access_set_addr_in, in, SET_PTR_WIDTH_IN_BITS, read entry index.
- read_port_data_out, out, SINGLE_ENTRY_WIDTH_IN_BITS, registered read data.
- read_port_valid_out, out, 1, registered flag: read entry has been written since reset.

Function
REQ-004 Storage SHALL be NUM_SET entries of SINGLE_ENTRY_WIDTH_IN_BITS plus one valid bit per entry.
REQ-005 Write: on a clock edge with access_en=1 and reset inactive, each byte whose write_en bit is 1 SHALL be updated; other bytes unchanged.
REQ-006 Write with access_en=1 and at least one write_en bit set SHALL set the entry valid bit; an all-zero mask SHALL change nothing.
REQ-007 Read latency SHALL be 1 cycle: outputs reflect the entry addressed at the edge where read_port_access_en_in=1.
REQ-008 If the addressed entry is invalid, read_port_valid_out SHALL be 0 and read_port_data_out SHALL be all zeros.
REQ-009 With read_port_access_en_in=0, both read outputs SHALL hold their previous values.
REQ-010 Reads and writes to different addresses in the same cycle SHALL be independent; the read returns the pre-existing contents.
REQ-011 On a same-address read/write collision with CONFIG_MODE "WriteFirst", outputs SHALL be the post-write merged entry with valid=1.
REQ-012 On a same-address collision with CONFIG_MODE "ReadFirst", outputs SHALL be the pre-write data and pre-write valid bit.
REQ-013 Out-of-range addresses (>= NUM_SET) SHALL be ignored on writes and SHALL read as invalid with zero data.

Reset
REQ-014 With reset_in=0 at a clock edge, all valid bits, read_port_data_out and read_port_valid_out SHALL clear to 0.
REQ-015 During reset, accesses SHALL be ignored; data array contents need not be cleared, so they remain RAM-inferable.
REQ-016 Reset asserted mid-operation SHALL discard any same-edge write and SHALL make every entry read invalid afterwards.

Configuration
REQ-017 With macro DUAL_PORT_BLOCK_RAM_OUTPUT_REG_EN defined, an extra output register stage SHALL be added, giving read latency 2 cycles; collision and hold rules are unchanged, and the stage is cleared by reset.
REQ-018 Without the macro, read latency SHALL be 1 cycle.

Verification (macro undefined, default parameters)
REQ-019 Write set 63 with 0x5555_5555_5555_5555 and mask 0xFF, then read set 63 -> next cycle data=0x5555_5555_5555_5555, valid=1.
REQ-020 After reset, read never-written set 1 -> valid=0, data=0.
REQ-021 Same cycle, write set 1 with 0xAAAA_AAAA_AAAA_AAAA and read set 63 -> data=0x5555_5555_5555_5555, valid=1; then read set 1 -> 0xAAAA_AAAA_AAAA_AAAA, valid=1.
REQ-022 Write set 5 with 0x1122334455667788 and mask 0x0F, then read set 5 -> data=0x0000000055667788, valid=1.
REQ-023 Collision: write and read set 7 with 0xDEADBEEF_00000000 -> "WriteFirst" gives new data and valid=1; "ReadFirst" gives 0 and valid=0.
REQ-024 Pulse reset_in low after writes, then read set 63 -> valid=0, data=0.
